// File: rtl/vc_flit_queue_if.sv
// rtl/vc_flit_queue_if.sv - flit type package and push/pop bundle for vc_flit_queue
package types;
    typedef logic [7:0] flit_t;
endpackage

interface vc_flit_queue_if #(
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 8
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    types::flit_t                   push_flit;
    logic [VC_W-1:0]                push_vc;
    logic                           push_valid;
    logic                           push_ready;
    logic [NUM_VC-1:0]              push_ready_vec;
    logic [VC_W-1:0]                pop_vc;
    logic                           pop_ready;
    logic                           pop_valid;
    types::flit_t                   pop_flit;
    logic [NUM_VC-1:0]              pop_valid_vec;
    logic [NUM_VC-1:0][CNT_W-1:0]   count;
    logic                           err;

    modport master (
        output push_flit, push_vc, push_valid, pop_vc, pop_ready,
        input  push_ready, push_ready_vec, pop_valid, pop_flit, pop_valid_vec, count, err
    );

    modport slave (
        input  push_flit, push_vc, push_valid, pop_vc, pop_ready,
        output push_ready, push_ready_vec, pop_valid, pop_flit, pop_valid_vec, count, err
    );
endinterface

// File: rtl/vc_flit_queue.sv
// rtl/vc_flit_queue.sv - NUM_VC independent flit FIFOs behind one push and one pop port
// Optional same-cycle empty-queue bypass when VC_QUEUE_BYPASS_EN is defined.
module vc_flit_queue #(
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 8
) (
    input logic           clk,
    input logic           rst_n,
    vc_flit_queue_if.slave q
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    types::flit_t     mem  [NUM_VC][DEPTH];
    logic [PTR_W-1:0] head [NUM_VC];
    logic [PTR_W-1:0] tail [NUM_VC];
    logic [CNT_W-1:0] cnt  [NUM_VC];
    logic [CNT_W:0]   cnt_nxt [NUM_VC];
    logic             err_q;

    logic              push_in, pop_in;
    logic [VC_W-1:0]   pi, oi;
    logic              push_ok, bypass_hit, pop_fire, push_store, pop_store, proto_err;
    logic [NUM_VC-1:0] over;

    function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Out-of-range selects are clamped to VC0 so array reads never go out of bounds.
    assign push_in = 32'(q.push_vc) < NUM_VC;
    assign pop_in  = 32'(q.pop_vc) < NUM_VC;
    assign pi      = push_in ? q.push_vc : '0;
    assign oi      = pop_in ? q.pop_vc : '0;

    assign q.push_ready = push_in && (cnt[pi] != FULL);
    assign push_ok      = q.push_valid && q.push_ready;

`ifdef VC_QUEUE_BYPASS_EN
    assign bypass_hit = push_ok && pop_in && (q.push_vc == q.pop_vc) && (cnt[oi] == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign q.pop_valid = pop_in && ((cnt[oi] != '0) || bypass_hit);
    assign q.pop_flit  = bypass_hit ? q.push_flit : mem[oi][tail[oi]];
    assign pop_fire    = q.pop_valid && q.pop_ready;

    // A consumed bypass flit never touches storage; an unconsumed one is stored normally.
    assign push_store = push_ok && !(bypass_hit && q.pop_ready);
    assign pop_store  = pop_fire && !bypass_hit;

    always_comb begin
        q.push_ready_vec = '0;
        q.pop_valid_vec  = '0;
        q.count          = '0;
        cnt_nxt          = '{default: '0};
        over             = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            q.push_ready_vec[v] = (cnt[v] != FULL);
            q.pop_valid_vec[v]  = (cnt[v] != '0);
            q.count[v]          = cnt[v];
            cnt_nxt[v] = {1'b0, cnt[v]}
                       + (CNT_W+1)'(push_store && (pi == VC_W'(v)))
                       - (CNT_W+1)'(pop_store && (oi == VC_W'(v)));
            over[v] = cnt_nxt[v] > (CNT_W+1)'(DEPTH);
        end
    end

    assign proto_err = (q.push_valid && !push_in) || (q.pop_ready && !pop_in) || (|over);
    assign q.err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                head[v] <= '0;
                tail[v] <= '0;
                cnt[v]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                cnt[v] <= cnt_nxt[v][CNT_W-1:0];
                if (push_store && (pi == VC_W'(v))) head[v] <= nxt_ptr(head[v]);
                if (pop_store && (oi == VC_W'(v)))  tail[v] <= nxt_ptr(tail[v]);
            end
            err_q <= err_q | proto_err;
        end
    end

    always_ff @(posedge clk) begin
        if (push_store) mem[pi][head[pi]] <= q.push_flit;
    end
endmodule

// File: tb/tb_vc_flit_queue.sv
// tb/tb_vc_flit_queue.sv - scoreboard bench for vc_flit_queue (4x8 and 3x5 instances)
module tb_vc_flit_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    types::flit_t q1[$];
    types::flit_t q2[$];
    types::flit_t q3[$];
    types::flit_t qb[$];
    types::flit_t e;

    always #5 clk = ~clk;

    vc_flit_queue_if #(.NUM_VC(4), .DEPTH(8)) ifa ();
    vc_flit_queue_if #(.NUM_VC(3), .DEPTH(5)) ifb ();

    vc_flit_queue #(.NUM_VC(4), .DEPTH(8)) u_a (.clk(clk), .rst_n(rst_n), .q(ifa.slave));
    vc_flit_queue #(.NUM_VC(3), .DEPTH(5)) u_b (.clk(clk), .rst_n(rst_n), .q(ifb.slave));

    task automatic step_a(input types::flit_t f, input logic [1:0] pvc, input logic pv,
                          input logic [1:0] ovc, input logic pr);
        @(negedge clk);
        ifa.push_flit = f; ifa.push_vc = pvc; ifa.push_valid = pv;
        ifa.pop_vc = ovc; ifa.pop_ready = pr;
        #1;
    endtask

    task automatic step_b(input types::flit_t f, input logic [1:0] pvc, input logic pv,
                          input logic [1:0] ovc, input logic pr);
        @(negedge clk);
        ifb.push_flit = f; ifb.push_vc = pvc; ifb.push_valid = pv;
        ifb.pop_vc = ovc; ifb.pop_ready = pr;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (ifa.count !== '0) begin errors++; $display("FAIL reset_count_a: got %h expected 0", ifa.count); end
        checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b expected 0", ifa.err); end
        checks++; if (ifa.push_ready_vec !== 4'hF) begin errors++; $display("FAIL reset_prv_a: got %b expected 1111", ifa.push_ready_vec); end
        checks++; if (ifa.pop_valid_vec !== 4'h0) begin errors++; $display("FAIL reset_pvv_a: got %b expected 0000", ifa.pop_valid_vec); end
        checks++; if (ifa.pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid_a: got %b expected 0", ifa.pop_valid); end
        checks++; if (ifa.push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready_a: got %b expected 1", ifa.push_ready); end
        step_b(8'h00, 2'd3, 1'b0, 2'd0, 1'b0);
        checks++; if (ifb.push_ready !== 1'b0) begin errors++; $display("FAIL reset_push_ready_oor_b: got %b expected 0", ifb.push_ready); end
        checks++; if (ifb.push_ready_vec !== 3'b111) begin errors++; $display("FAIL reset_prv_b: got %b expected 111", ifb.push_ready_vec); end
        step_b(8'h00, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_order();
        for (int i = 0; i < 3; i++) begin
            step_a(8'hA1 + 8'(i), 2'd2, 1'b1, 2'd2, 1'b0);
            checks++; if (ifa.push_ready !== 1'b1) begin errors++; $display("FAIL order_push_ready: got %b expected 1", ifa.push_ready); end
            if (i > 0) begin
                checks++; if (ifa.count[2] !== 4'(i)) begin errors++; $display("FAIL order_count_up: got %0d expected %0d", ifa.count[2], i); end
            end
            q2.push_back(8'hA1 + 8'(i));
        end
        step_a(8'h00, 2'd0, 1'b0, 2'd2, 1'b0);
        checks++; if (ifa.count[2] !== 4'd3) begin errors++; $display("FAIL order_count_full: got %0d expected 3", ifa.count[2]); end
        checks++; if (ifa.pop_valid_vec[2] !== 1'b1) begin errors++; $display("FAIL order_pvv_set: got %b expected 1", ifa.pop_valid_vec[2]); end
        for (int i = 0; i < 3; i++) begin
            step_a(8'h00, 2'd0, 1'b0, 2'd2, 1'b1);
            checks++; if (ifa.count[2] !== 4'(3 - i)) begin errors++; $display("FAIL order_count_down: got %0d expected %0d", ifa.count[2], 3 - i); end
            checks++; if (ifa.pop_valid !== 1'b1) begin errors++; $display("FAIL order_pop_valid: got %b expected 1", ifa.pop_valid); end
            e = q2.pop_front();
            checks++; if (ifa.pop_flit !== e) begin errors++; $display("FAIL order_data: got %h expected %h", ifa.pop_flit, e); end
        end
        step_a(8'h00, 2'd0, 1'b0, 2'd2, 1'b0);
        checks++; if (ifa.count[2] !== 4'd0) begin errors++; $display("FAIL order_count_empty: got %0d expected 0", ifa.count[2]); end
        checks++; if (ifa.pop_valid_vec[2] !== 1'b0) begin errors++; $display("FAIL order_pvv_drop: got %b expected 0", ifa.pop_valid_vec[2]); end
    endtask

    task automatic test_same_cycle();
        step_a(8'h11, 2'd1, 1'b1, 2'd0, 1'b0); q1.push_back(8'h11);
        step_a(8'h12, 2'd1, 1'b1, 2'd0, 1'b0); q1.push_back(8'h12);
        step_a(8'h31, 2'd3, 1'b1, 2'd0, 1'b0); q3.push_back(8'h31);
        step_a(8'h32, 2'd3, 1'b1, 2'd0, 1'b0); q3.push_back(8'h32);
        step_a(8'h13, 2'd1, 1'b1, 2'd3, 1'b1); q1.push_back(8'h13);
        e = q3.pop_front();
        checks++; if (ifa.pop_flit !== e) begin errors++; $display("FAIL diffvc_data: got %h expected %h", ifa.pop_flit, e); end
        step_a(8'h00, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (ifa.count[1] !== 4'd3) begin errors++; $display("FAIL diffvc_count1: got %0d expected 3", ifa.count[1]); end
        checks++; if (ifa.count[3] !== 4'd1) begin errors++; $display("FAIL diffvc_count3: got %0d expected 1", ifa.count[3]); end
        step_a(8'h00, 2'd0, 1'b0, 2'd1, 1'b1);
        e = q1.pop_front();
        checks++; if (ifa.pop_flit !== e) begin errors++; $display("FAIL samevc_pre_data: got %h expected %h", ifa.pop_flit, e); end
        step_a(8'h14, 2'd1, 1'b1, 2'd1, 1'b1); q1.push_back(8'h14);
        checks++; if (ifa.count[1] !== 4'd2) begin errors++; $display("FAIL samevc_count_pre: got %0d expected 2", ifa.count[1]); end
        e = q1.pop_front();
        checks++; if (ifa.pop_flit !== e) begin errors++; $display("FAIL samevc_data: got %h expected %h", ifa.pop_flit, e); end
        step_a(8'h00, 2'd0, 1'b0, 2'd1, 1'b0);
        checks++; if (ifa.count[1] !== 4'd2) begin errors++; $display("FAIL samevc_count_post: got %0d expected 2", ifa.count[1]); end
        while (q1.size() > 0) begin
            step_a(8'h00, 2'd0, 1'b0, 2'd1, 1'b1);
            e = q1.pop_front();
            checks++; if (ifa.pop_flit !== e) begin errors++; $display("FAIL drain1_data: got %h expected %h", ifa.pop_flit, e); end
        end
        step_a(8'h00, 2'd0, 1'b0, 2'd3, 1'b1);
        e = q3.pop_front();
        checks++; if (ifa.pop_flit !== e) begin errors++; $display("FAIL drain3_data: got %h expected %h", ifa.pop_flit, e); end
        step_a(8'h00, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (ifa.pop_valid_vec !== 4'h0) begin errors++; $display("FAIL drain_pvv: got %b expected 0000", ifa.pop_valid_vec); end
    endtask

    task automatic test_bypass();
        step_a(8'h5C, 2'd1, 1'b1, 2'd1, 1'b1);
`ifdef VC_QUEUE_BYPASS_EN
        checks++; if (ifa.pop_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", ifa.pop_valid); end
        checks++; if (ifa.pop_flit !== 8'h5C) begin errors++; $display("FAIL bypass_data: got %h expected 5c", ifa.pop_flit); end
        step_a(8'h00, 2'd0, 1'b0, 2'd1, 1'b0);
        checks++; if (ifa.count[1] !== 4'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", ifa.count[1]); end
        checks++; if (ifa.pop_valid !== 1'b0) begin errors++; $display("FAIL bypass_after: got %b expected 0", ifa.pop_valid); end
`else
        checks++; if (ifa.pop_valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid: got %b expected 0", ifa.pop_valid); end
        step_a(8'h00, 2'd0, 1'b0, 2'd1, 1'b1);
        checks++; if (ifa.pop_valid !== 1'b1) begin errors++; $display("FAIL nobypass_next_valid: got %b expected 1", ifa.pop_valid); end
        checks++; if (ifa.pop_flit !== 8'h5C) begin errors++; $display("FAIL nobypass_data: got %h expected 5c", ifa.pop_flit); end
        checks++; if (ifa.count[1] !== 4'd1) begin errors++; $display("FAIL nobypass_count: got %0d expected 1", ifa.count[1]); end
        step_a(8'h00, 2'd0, 1'b0, 2'd1, 1'b0);
        checks++; if (ifa.count[1] !== 4'd0) begin errors++; $display("FAIL nobypass_drain: got %0d expected 0", ifa.count[1]); end
`endif
        checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL a_err_clean: got %b expected 0", ifa.err); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 5; i++) begin
            step_b(8'h10 + 8'(i), 2'd0, 1'b1, 2'd0, 1'b0);
            checks++; if (ifb.push_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b expected 1", ifb.push_ready); end
            qb.push_back(8'h10 + 8'(i));
        end
        step_b(8'hEE, 2'd0, 1'b1, 2'd0, 1'b0);
        checks++; if (ifb.count[0] !== 3'd5) begin errors++; $display("FAIL full_count: got %0d expected 5", ifb.count[0]); end
        checks++; if (ifb.push_ready_vec[0] !== 1'b0) begin errors++; $display("FAIL full_prv: got %b expected 0", ifb.push_ready_vec[0]); end
        checks++; if (ifb.push_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", ifb.push_ready); end
        step_b(8'hEE, 2'd0, 1'b1, 2'd0, 1'b1);
        checks++; if (ifb.count[0] !== 3'd5) begin errors++; $display("FAIL full_nowrite: got %0d expected 5", ifb.count[0]); end
        checks++; if (ifb.push_ready !== 1'b0) begin errors++; $display("FAIL full_pop_push_ready: got %b expected 0", ifb.push_ready); end
        e = qb.pop_front();
        checks++; if (ifb.pop_flit !== e) begin errors++; $display("FAIL full_pop_data: got %h expected %h", ifb.pop_flit, e); end
        step_b(8'hEE, 2'd0, 1'b1, 2'd0, 1'b0);
        checks++; if (ifb.count[0] !== 3'd4) begin errors++; $display("FAIL full_pop_count: got %0d expected 4", ifb.count[0]); end
        qb.push_back(8'hEE);
        for (int k = 0; k < 11; k++) begin
            step_b(8'h00, 2'd0, 1'b0, 2'd0, 1'b1);
            e = qb.pop_front();
            checks++; if (ifb.pop_flit !== e) begin errors++; $display("FAIL wrap_data: got %h expected %h", ifb.pop_flit, e); end
            step_b(8'h20 + 8'(k), 2'd0, 1'b1, 2'd0, 1'b0);
            checks++; if (ifb.push_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b expected 1", ifb.push_ready); end
            qb.push_back(8'h20 + 8'(k));
        end
        step_b(8'h00, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (ifb.count[0] !== 3'd5) begin errors++; $display("FAIL wrap_count: got %0d expected 5", ifb.count[0]); end
        while (qb.size() > 0) begin
            step_b(8'h00, 2'd0, 1'b0, 2'd0, 1'b1);
            e = qb.pop_front();
            checks++; if (ifb.pop_flit !== e) begin errors++; $display("FAIL wrap_drain: got %h expected %h", ifb.pop_flit, e); end
        end
        step_b(8'h00, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (ifb.pop_valid_vec !== 3'b000) begin errors++; $display("FAIL wrap_empty: got %b expected 000", ifb.pop_valid_vec); end
    endtask

    task automatic test_err();
        step_b(8'h00, 2'd3, 1'b1, 2'd3, 1'b0);
        checks++; if (ifb.push_ready !== 1'b0) begin errors++; $display("FAIL err_push_ready: got %b expected 0", ifb.push_ready); end
        checks++; if (ifb.pop_valid !== 1'b0) begin errors++; $display("FAIL err_pop_valid: got %b expected 0", ifb.pop_valid); end
        checks++; if (ifb.err !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", ifb.err); end
        step_b(8'h77, 2'd1, 1'b1, 2'd0, 1'b0);
        checks++; if (ifb.err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", ifb.err); end
        for (int i = 0; i < 3; i++) begin
            step_b(8'h00, 2'd0, 1'b0, 2'd0, 1'b0);
            checks++; if (ifb.err !== 1'b1) begin errors++; $display("FAIL err_hold: got %b expected 1", ifb.err); end
        end
        checks++; if (ifb.count[1] !== 3'd1) begin errors++; $display("FAIL err_count_pre: got %0d expected 1", ifb.count[1]); end
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (ifb.err !== 1'b0) begin errors++; $display("FAIL async_err_clear: got %b expected 0", ifb.err); end
        checks++; if (ifb.count[1] !== 3'd0) begin errors++; $display("FAIL async_count_clear: got %0d expected 0", ifb.count[1]); end
        @(negedge clk); rst_n = 1'b1;
        step_b(8'h00, 2'd0, 1'b0, 2'd3, 1'b1);
        checks++; if (ifb.err !== 1'b0) begin errors++; $display("FAIL err_after_reset: got %b expected 0", ifb.err); end
        step_b(8'h00, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (ifb.err !== 1'b1) begin errors++; $display("FAIL err_pop_oor: got %b expected 1", ifb.err); end
    endtask

    initial begin
        ifa.push_flit = '0; ifa.push_vc = '0; ifa.push_valid = 1'b0; ifa.pop_vc = '0; ifa.pop_ready = 1'b0;
        ifb.push_flit = '0; ifb.push_vc = '0; ifb.push_valid = 1'b0; ifb.pop_vc = '0; ifb.pop_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_order();
        test_same_cycle();
        test_bypass();
        test_full_wrap();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
